// File: rtl/alu_exec_scheduler_pkg.sv
// alu_sched_pkg: types and constants shared by the ALU exec scheduler, its
// arbiter and the issue-side decoder.
//   sched_state_t : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   alu_req_t     : one latched issue request (opcode, imm, operands, tag)
//   OP_*          : opcode numbers shared with the decoder
//   sext16()      : sign-extend a 16-bit immediate to 32 bits
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [5:0]  inst_num;
    logic [15:0] const16;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  tag;
  } alu_req_t;

  localparam logic [5:0] OP_ADD  = 6'd8;
  localparam logic [5:0] OP_ADDI = 6'd9;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_exec_scheduler_if.sv
// alu_exec_scheduler_if: issue ports, result port and ALU element drive of the
// scheduler, bundled in one interface.
//   master : the scheduler (drives req_ready, res_*, elem operands/reset)
//   slave  : the environment (issuers, result consumer, ALU element)
interface alu_exec_scheduler_if #(
  parameter int NUM_REQ = 2
);
  // issue side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][5:0]   req_inst_num;
  logic [NUM_REQ-1:0][15:0]  req_const16;
  logic [NUM_REQ-1:0][31:0]  req_rs;
  logic [NUM_REQ-1:0][31:0]  req_rt;
  logic [NUM_REQ-1:0][3:0]   req_tag;
  // result side
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [3:0]  res_tag;
  logic [31:0] res_data;
  logic        res_timeout;
  // ALU element side
  logic        elem_reset;
  logic        elem_completed;
  logic [31:0] elem_out;
  logic [5:0]  elem_inst_num;
  logic [15:0] elem_const16;
  logic [31:0] elem_const16_x;
  logic [4:0]  elem_shift5;
  logic [31:0] elem_rs;
  logic [31:0] elem_rt;

  modport master (
    input  req_valid, req_inst_num, req_const16, req_rs, req_rt, req_tag,
    input  res_ready, elem_completed, elem_out,
    output req_ready, res_valid, res_id, res_tag, res_data, res_timeout,
    output elem_reset, elem_inst_num, elem_const16, elem_const16_x,
    output elem_shift5, elem_rs, elem_rt
  );

  modport slave (
    output req_valid, req_inst_num, req_const16, req_rs, req_rt, req_tag,
    output res_ready, elem_completed, elem_out,
    input  req_ready, res_valid, res_id, res_tag, res_data, res_timeout,
    input  elem_reset, elem_inst_num, elem_const16, elem_const16_x,
    input  elem_shift5, elem_rs, elem_rt
  );
endinterface

// File: rtl/alu_exec_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. Picks the first requesting
// port strictly after i_ptr, wrapping modulo NUM_REQ.
//   i_req    : request vector
//   i_ptr    : last granted port
//   o_gnt    : one-hot grant (zero when no request)
//   o_gnt_id : index of the granted port
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [1:0]         o_gnt_id
);
  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found       = 1'b1;
        o_gnt[w_idx]  = 1'b1;
        o_gnt_id      = 2'(w_idx);
      end
    end
  end
endmodule

// File: rtl/alu_exec_scheduler.sv
// alu_exec_scheduler: shares one ALU exec element between NUM_REQ issue ports.
// Accepts one op per handshake, latches operands, releases the element reset,
// waits for completion (or watchdog), and returns result+id+tag on a
// valid/ready port.
//   clk, reset : clock, async active-high reset
//   bus        : issue ports, result port and element drive (master side)
module alu_exec_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_exec_scheduler_if.master bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]    r_state;
  logic [1:0]    r_ptr;
  logic [1:0]    r_id;
  logic [CW-1:0] r_cnt;
  alu_req_t      r_req;
  logic          r_res_valid;
  logic          r_res_timeout;
  logic [31:0]   r_res_data;
  logic          r_elem_reset;

  alu_req_t [NUM_REQ-1:0] w_req;
  alu_req_t               w_sel;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [1:0]             w_gnt_id;
  logic                   w_idle;
  logic                   w_accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_req[g] = {bus.req_inst_num[g], bus.req_const16[g],
                       bus.req_rs[g], bus.req_rt[g], bus.req_tag[g]};
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req    (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  // one-hot grant, so an OR-mux selects the winning request
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_gnt[i]) w_sel = w_sel | w_req[i];
  end

  assign w_idle        = (r_state == S_IDLE);
  assign w_accept      = w_idle && (|bus.req_valid);
  assign bus.req_ready = w_idle ? w_gnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= 2'(NUM_REQ - 1);
      r_id          <= '0;
      r_cnt         <= '0;
      r_req         <= '0;
      r_res_valid   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_data    <= '0;
      r_elem_reset  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req        <= w_sel;
            r_id         <= w_gnt_id;
            r_ptr        <= w_gnt_id;
            r_elem_reset <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        // element computes on the edge leaving ISSUE; its completed was
        // held clear by elem_reset until now, so nothing stale is seen
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.elem_completed) begin
            r_res_data    <= bus.elem_out;
            r_res_timeout <= 1'b0;
            r_res_valid   <= 1'b1;
            r_elem_reset  <= 1'b1;
            r_state       <= S_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_res_valid   <= 1'b1;
            r_elem_reset  <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.res_valid      = r_res_valid;
  assign bus.res_id         = r_id;
  assign bus.res_tag        = r_req.tag;
  assign bus.res_data       = r_res_data;
  assign bus.res_timeout    = r_res_timeout;
  assign bus.elem_reset     = r_elem_reset;
  assign bus.elem_inst_num  = r_req.inst_num;
  assign bus.elem_const16   = r_req.const16;
  assign bus.elem_const16_x = sext16(r_req.const16);
  assign bus.elem_shift5    = r_req.const16[10:6];
  assign bus.elem_rs        = r_req.rs;
  assign bus.elem_rt        = r_req.rt;
endmodule

// File: doc/alu_exec_scheduler.md
# alu_exec_scheduler

Sequencer and round-robin arbiter that shares one ALU exec element between `NUM_REQ` issue ports. It accepts one operation per port handshake and latches the operands. It starts the element by releasing its synchronous `reset`, waits for `completed`, and returns the result with the requester id and tag on a valid/ready result port. It sits between the issue stage and the ALU exec element. It owns the element's `reset` input exclusively.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `TIMEOUT`, default 64: cycles spent in WAIT before the watchdog forces completion.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-port request valid.
- `req_ready`  out  NUM_REQ  per-port accept; one-hot or zero.
- `req_inst_num`  in  NUM_REQ×6  opcode per port.
- `req_const16`  in  NUM_REQ×16  immediate per port.
- `req_rs`, `req_rt`  in  NUM_REQ×32  operands per port.
- `req_tag`  in  NUM_REQ×4  opaque tag, echoed on the result.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumer ready.
- `res_id`  out  2  index of the granted requester.
- `res_tag`  out  4  echoed tag.
- `res_data`  out  32  element result, or 0 on timeout.
- `res_timeout`  out  1  result was produced by the watchdog.
- `elem_reset`  out  1  drives the element's `reset`.
- `elem_completed`  in  1  element's `completed`.
- `elem_out`  in  32  element's `out`.
- `elem_inst_num`, `elem_const16`, `elem_const16_x`, `elem_shift5`, `elem_rs`, `elem_rt`  out  6/16/32/5/32/32  operand drive to the element.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Async reset puts the block in IDLE.
- Reset values:
  - `elem_reset` = 1.
  - `req_ready`, `res_valid`, `res_timeout` = 0.
  - `res_id`, `res_tag`, `res_data` = 0.
  - Operand registers = 0.
  - Round-robin pointer = `NUM_REQ`-1, so port 0 wins first.
- IDLE:
  - `elem_reset` held at 1.
  - If any `req_valid` is high, grant the first valid port at or after pointer+1, wrapping modulo `NUM_REQ`.
  - `req_ready` is driven combinationally, one-hot, for the granted port only.
  - On the accepting edge: latch opcode, const16, rs, rt, tag and id; set pointer = grant; go to ISSUE; `elem_reset` becomes 0.
- ISSUE:
  - Lasts one cycle. `elem_completed` is ignored.
  - Go to WAIT with the watchdog count cleared.
- WAIT:
  - When `elem_completed` = 1: capture `elem_out` into `res_data`, `res_timeout` = 0, `res_valid` = 1, `elem_reset` = 1, go to DONE.
  - Otherwise increment the count. When count reaches `TIMEOUT`-1 with no completion: `res_data` = 0, `res_timeout` = 1, `res_valid` = 1, `elem_reset` = 1, go to DONE.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE:
  - Outputs hold stable while `res_ready` = 0.
  - On `res_valid` & `res_ready`, clear `res_valid` and go to IDLE.
  - No request is accepted in the handshake cycle itself.
- Operand mapping:
  - `elem_const16_x` = sign-extension of const16.
  - `elem_shift5` = const16[10:6].
  - Element pc, addr26, rd and float inputs are tied to 0 at instantiation.
- Opcodes are not validated. Unknown opcodes complete in one cycle per element behaviour.
- `req_valid` dropping while not granted is legal. Nothing is queued.
- Async reset mid-operation aborts the operation: the result is lost, `elem_reset` = 1 immediately, `res_valid` = 0.

## Timing
- Accept edge E0 → ISSUE; E1 → WAIT, and the element computes at E1; E2 → DONE with `res_valid` high.
- Result latency is 2 cycles from acceptance for single-cycle element ops.
- Minimum spacing between accepts is 4 cycles: accept, ISSUE, WAIT, DONE handshake, then back in IDLE.
- `elem_reset` is high at the accept edge, so the element's `completed` is cleared before ISSUE. A stale `completed` can never be captured.
- Watchdog: `res_valid` rises `TIMEOUT`+1 cycles after acceptance.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, state and pointer.

## Structure
- Package `alu_sched_pkg` holds:
  - `sched_state_t` enum (IDLE, ISSUE, WAIT, DONE).
  - `alu_req_t` struct (inst_num, const16, rs, rt, tag).
  - Opcode constants shared with the decoder.
- Sub-module `rr_arbiter`: combinational one-hot grant from request vector and pointer. Parameterised by `NUM_REQ`.
- The element itself is instantiated outside this block.

## Test plan
- Port 0 sends ADD (8), rs=5, rt=7, tag=3 → `res_valid` 2 cycles after accept; `res_data`=12, `res_id`=0, `res_tag`=3, `res_timeout`=0.
- Port 1 sends ADDI (9), rs=10, const16=0xFFFF → `elem_const16_x`=0xFFFFFFFF and `res_data`=9.
- Both ports valid continuously, `res_ready`=1 → grants alternate 0,1,0,1. Each accept is ≥4 cycles apart. No port is starved.
- Hold `res_ready`=0 for 5 cycles in DONE → outputs stable, no `req_ready` asserted; accept resumes the cycle after the handshake.
- `TIMEOUT`=8, element model holds `completed`=0 → `res_valid` 9 cycles after accept with `res_data`=0 and `res_timeout`=1; the next op completes normally.
- Assert `reset` asynchronously mid-WAIT → `elem_reset`=1 and `res_valid`=0 immediately. After release, port 0 is granted first and its result is correct.
